// File: rtl/lcd_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lcd_read_ctrl
// Description : HD44780-style 8-bit read-cycle sequencer. Drives RS/RW, a
//               timed E strobe and the FPGA bus-driver enable. Samples the
//               LCD data bus once per strobe and returns the byte, the busy
//               flag and the address counter. It can optionally re-poll the
//               busy flag until it clears or a poll limit is reached.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               i_start            - read request, taken only when o_ready=1
//               i_rs_sel           - 0 busy/address read, 1 data read
//               i_poll             - repeat busy reads until BF=0
//               i_lcd_db_in        - LCD data bus input
//               o_lcd_rs/rw/e      - LCD control pins
//               o_lcd_db_oe        - FPGA data bus driver enable
//               o_ready            - idle, can accept a request
//               o_rd_data/o_busy_flag/o_addr - last sampled result
//               o_valid            - one-cycle pulse when results update
//               o_timeout          - sticky poll-exhaustion flag
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_read_ctrl #(
  parameter int T_AS      = 4,
  parameter int T_EH      = 25,
  parameter int T_DDR     = 20,
  parameter int T_REC     = 25,
  parameter int MAX_POLLS = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_rs_sel,
  input  logic       i_poll,
  input  logic [7:0] i_lcd_db_in,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_e,
  output logic       o_lcd_db_oe,
  output logic       o_ready,
  output logic [7:0] o_rd_data,
  output logic       o_busy_flag,
  output logic [6:0] o_addr,
  output logic       o_valid,
  output logic       o_timeout
);

  localparam int C_T_MAX0 = (T_AS > T_EH) ? T_AS : T_EH;
  localparam int C_T_MAX  = (C_T_MAX0 > T_REC) ? C_T_MAX0 : T_REC;
  localparam int CW       = $clog2(C_T_MAX) + 1;
  localparam int PW       = $clog2(MAX_POLLS) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_EHIGH = 2'd2;
  localparam logic [1:0] S_REC   = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_polls;
  logic          r_rs_l;
  logic          r_poll_l;
  logic [7:0]    r_sample;
  logic [7:0]    r_rd_data;
  logic          r_valid;
  logic          r_timeout;
  logic          r_e;
  logic          r_rw;
  logic          r_oe;
  logic          r_ready;

  logic [1:0]    w_state_nx;
  logic          w_accept;
  logic          w_step_end;
  logic          w_busy;
  logic [PW-1:0] w_polls_inc;
  logic          w_hit_max;
  logic          w_rec_end;
  logic          w_finish;
  logic          w_repoll;
  logic          w_sample_now;

  always_comb begin
    w_accept   = (r_state == S_IDLE) && r_ready && i_start;
    w_step_end = 1'b0;
    case (r_state)
      S_SETUP: w_step_end = (r_cnt == CW'(T_AS - 1));
      S_EHIGH: w_step_end = (r_cnt == CW'(T_EH - 1));
      S_REC:   w_step_end = (r_cnt == CW'(T_REC - 1));
      default: w_step_end = 1'b0;
    endcase

    // Busy polling only applies to instruction-register reads.
    w_busy       = r_poll_l & ~r_rs_l & r_sample[7];
    // Saturating increment; the count never needs to exceed MAX_POLLS.
    w_polls_inc  = (r_polls == PW'(MAX_POLLS)) ? r_polls : r_polls + PW'(1);
    w_hit_max    = (w_polls_inc == PW'(MAX_POLLS));
    w_rec_end    = (r_state == S_REC) && w_step_end;
    w_finish     = w_rec_end && (!w_busy || w_hit_max);
    w_repoll     = w_rec_end && w_busy && !w_hit_max;
    w_sample_now = (r_state == S_EHIGH) && (r_cnt == CW'(T_DDR - 1));

    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)   w_state_nx = S_SETUP;
      S_SETUP: if (w_step_end) w_state_nx = S_EHIGH;
      S_EHIGH: if (w_step_end) w_state_nx = S_REC;
      S_REC: begin
        if (w_finish)      w_state_nx = S_IDLE;
        else if (w_repoll) w_state_nx = S_SETUP;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_polls   <= '0;
      r_rs_l    <= 1'b0;
      r_poll_l  <= 1'b0;
      r_sample  <= 8'h00;
      r_rd_data <= 8'h00;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_e       <= 1'b0;
      r_rw      <= 1'b0;
      r_oe      <= 1'b1;
      r_ready   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      // Phase counter restarts on every state change and rests at 0 in IDLE.
      if (w_state_nx != r_state || r_state == S_IDLE) r_cnt <= '0;
      else                                            r_cnt <= r_cnt + CW'(1);

      r_ready <= (w_state_nx == S_IDLE);
      r_e     <= (w_state_nx == S_EHIGH);
      r_rw    <= (w_state_nx != S_IDLE);
      // Driver stays off through the cycle RW falls, so it turns on one
      // cycle after the LCD has stopped driving the bus.
      r_oe    <= ~w_accept & ~r_rw;
      r_valid <= w_finish;

      if (w_accept) begin
        r_rs_l    <= i_rs_sel;
        r_poll_l  <= i_poll;
        r_polls   <= '0;
        r_timeout <= 1'b0;
      end else if (w_finish) begin
        r_rs_l <= 1'b0;
      end

      if (w_rec_end && w_busy) r_polls <= w_polls_inc;
      if (w_finish && w_busy)  r_timeout <= 1'b1;

      if (w_sample_now) r_sample  <= i_lcd_db_in;
      if (w_finish)     r_rd_data <= r_sample;
    end
  end

  assign o_lcd_rs    = r_rs_l;
  assign o_lcd_rw    = r_rw;
  assign o_lcd_e     = r_e;
  assign o_lcd_db_oe = r_oe;
  assign o_ready     = r_ready;
  assign o_rd_data   = r_rd_data;
  assign o_busy_flag = r_rd_data[7];
  assign o_addr      = r_rd_data[6:0];
  assign o_valid     = r_valid;
  assign o_timeout   = r_timeout;

endmodule
`default_nettype wire

// File: doc/lcd_read_ctrl.md
Name: lcd_read_ctrl

Overview:
Read-side counterpart to the LCD enable-strobe generator. It runs HD44780-style read cycles in 8-bit mode and produces the LCD pin sequence: RS/RW setup, a timed E pulse, data sampling and recovery. It returns the busy flag and address counter, or a data byte. Optionally it polls the busy flag until it clears, so the write path can wait on it before issuing the next command.

Parameters:
T_AS, 4, cycles RS/RW stable before E rises (min 1)
T_EH, 25, cycles E held high (min 2)
T_DDR, 20, cycle index within E-high at which lcd_db_in is sampled (1..T_EH)
T_REC, 25, cycles E low after each pulse before next action (min 1)
MAX_POLLS, 1023, busy polls before timeout (min 1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start  in  1  request; accepted only when ready=1
rs_sel  in  1  0 = busy-flag/address read, 1 = data-register read; latched on accept
poll  in  1  1 = repeat busy read until BF=0 (ignored when rs_sel=1); latched on accept
lcd_db_in  in  8  LCD data bus input
lcd_rs  out  1  register select to LCD
lcd_rw  out  1  read/write to LCD (1 = read)
lcd_e  out  1  enable strobe to LCD
lcd_db_oe  out  1  FPGA bus driver enable; 0 throughout any read
ready  out  1  idle, can accept start
rd_data  out  8  last sampled byte
busy_flag  out  1  rd_data[7] of last busy read
addr  out  7  rd_data[6:0] of last busy read
valid  out  1  one-cycle pulse when rd_data/busy_flag/addr update
timeout  out  1  sticky; set on poll exhaustion, cleared on next accepted start

Behaviour:
- Reset (rst=0, async) values: lcd_e=0, lcd_rw=0, lcd_rs=0, lcd_db_oe=1, ready=0 while asserted, rd_data=0, busy_flag=0, addr=0, valid=0, timeout=0, state=IDLE, all counters 0. ready=1 in the first cycle after deassertion.
- A reset mid-cycle drops lcd_e immediately and restores lcd_db_oe=1. No valid is produced.
- IDLE: ready=1, lcd_rw=0, lcd_db_oe=1.
  - start=1: latch rs_sel and poll, clear timeout and the poll counter, go to SETUP.
  - Next cycle: ready=0, lcd_rw=1, lcd_db_oe=0, lcd_rs=latched rs_sel.
- SETUP: hold T_AS cycles, then go to EHIGH. lcd_e rises on the first EHIGH cycle, exactly T_AS cycles after lcd_rw rises.
- EHIGH: lcd_e=1 for exactly T_EH cycles.
  - On EHIGH cycle T_DDR (1-based), register lcd_db_in into an internal sample register.
  - After T_EH cycles go to REC.
- REC: lcd_e=0 for T_REC cycles, with lcd_rw/lcd_rs held. At the end of REC:
  - If rs_sel=1, or poll=0: update outputs, pulse valid for 1 cycle, go to IDLE.
  - If poll=1 and sample[7]=1: increment the poll counter. If count == MAX_POLLS, update outputs, set timeout, pulse valid, go to IDLE. Otherwise go back to SETUP with no valid.
  - If poll=1 and sample[7]=0: update outputs, pulse valid, go to IDLE.
- Output update: rd_data = sample, busy_flag = sample[7], addr = sample[6:0]. Updates occur in the same cycle as valid.
- Bus contention rule: lcd_db_oe=0 from the cycle lcd_rw rises until the cycle after it falls. lcd_rw falls only in the IDLE-return cycle, which is also when valid is 1.
- start while ready=0 is ignored; there is no queuing.
- lcd_e never has a high phase shorter than T_EH. There are no back-to-back pulses without T_REC low.
- Single-read latency, from start accepted to valid: T_AS + T_EH + T_REC + 1 cycles (55 with defaults).
- Counter widths: $clog2 of the max parameter +1. The poll counter saturates; it does not wrap.

Test Plan:
- Reset: hold rst=0 with start=1 -> lcd_e=0, lcd_db_oe=1, valid=0, ready=0. After release, ready=1 in the next cycle.
- Single busy read: rs_sel=0, poll=0, lcd_db_in=8'h25 -> lcd_e high for exactly 25 cycles, 4 cycles after lcd_rw=1. valid 55 cycles after accept with busy_flag=0, addr=7'h25, rd_data=8'h25.
- Data read: rs_sel=1, poll=1, lcd_db_in=8'hC3 -> lcd_rs=1 throughout, single E pulse (poll ignored), rd_data=8'hC3, valid once.
- Polling: poll=1, lcd_db_in=8'h80 for the first 3 pulses then 8'h0A -> exactly 4 E pulses, each separated by ≥25 low cycles. One valid, with busy_flag=0, addr=7'h0A, timeout=0.
- Timeout: MAX_POLLS=3, lcd_db_in stuck at 8'hFF -> 3 pulses, then valid with timeout=1, busy_flag=1. The next start clears timeout.
- Mid-operation reset: assert rst=0 during EHIGH -> lcd_e falls asynchronously, no valid. A new start after release completes normally. start pulses while ready=0 produce no extra cycle.
